// File: rtl/qpsk_pkg.sv
// Shared QPSK receive types: dibit encoding, sample format and receive sequencer states.
package qpsk_pkg;

    localparam int unsigned QPSK_SAMPLE_W = 16;
    localparam int unsigned QPSK_FRAC     = 7;

    typedef logic [1:0] dibit_t;

    localparam dibit_t DIBIT_00 = 2'b00;
    localparam dibit_t DIBIT_01 = 2'b01;
    localparam dibit_t DIBIT_10 = 2'b10;
    localparam dibit_t DIBIT_11 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        PAYLOAD,
        DONE
    } rx_state_t;

endpackage

// File: rtl/qpsk_slicer.sv
// Registered QPSK hard-decision slicer: strict sign test per rail, zero decides negative.
module qpsk_slicer
    import qpsk_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic signed [QPSK_SAMPLE_W-1:0] in_i,
    input  logic signed [QPSK_SAMPLE_W-1:0] in_q,
    output dibit_t                          dibit,
    output logic                            dvalid
);

    logic i_le0_c;
    logic q_le0_c;

    assign i_le0_c = in_i[QPSK_SAMPLE_W-1] | ~(|in_i);
    assign q_le0_c = in_q[QPSK_SAMPLE_W-1] | ~(|in_q);

    // Dibit MSB follows Q, LSB follows I; held between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dibit  <= DIBIT_00;
            dvalid <= 1'b0;
        end else begin
            dvalid <= in_valid;
            if (in_valid) begin
                dibit <= {q_le0_c, i_le0_c};
            end
        end
    end

endmodule

// File: rtl/qpsk_rx_frame_ctrl.sv
// QPSK receive sequencer: symbol strobe, slicing, sync-word hunt and payload byte packing
// onto a single-entry valid/ready output register.
module qpsk_rx_frame_ctrl
    import qpsk_pkg::*;
#(
    parameter int unsigned SPS         = 4,
    parameter int unsigned SYNC_DIBITS = 8,
    parameter logic [31:0] SYNC_WORD   = 32'h0000_D391,
    parameter int unsigned LEN_W       = 8,
    localparam int unsigned PH_W       = (SPS > 1) ? $clog2(SPS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [PH_W-1:0]                 phase,
    input  logic [LEN_W-1:0]                payload_len,
    input  logic                            in_valid,
    input  logic signed [QPSK_SAMPLE_W-1:0] in_i,
    input  logic signed [QPSK_SAMPLE_W-1:0] in_q,
    output logic [7:0]                      byte_data,
    output logic                            byte_valid,
    input  logic                            byte_ready,
    output logic                            sync_found,
    output logic                            frame_done,
    output logic                            overflow,
    output logic                            busy
);

    localparam int unsigned SR_W   = 2 * SYNC_DIBITS;
    localparam int unsigned FILL_W = 5;

    rx_state_t         state, state_d;
    logic [PH_W-1:0]   cnt, cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SR_W-1:0]   sr, sr_d;
    logic [FILL_W-1:0] fill, fill_d;
    logic [5:0]        pk, pk_d;
    logic [1:0]        dcnt, dcnt_d;
    logic [LEN_W-1:0]  bcnt, bcnt_d;
    logic [7:0]        byte_data_d;
    logic              byte_valid_d, sync_found_d, frame_done_d, overflow_d, busy_d;
    logic              complete;

    logic              strobe_c;
    dibit_t            dibit;
    logic              dvalid;
    logic [SR_W-1:0]   sr_upd_c;
    logic [FILL_W-1:0] fill_upd_c;

    assign strobe_c   = in_valid && (cnt == phase_q);
    assign sr_upd_c   = SR_W'({sr, dibit});
    assign fill_upd_c = (fill == FILL_W'(SYNC_DIBITS)) ? fill : fill + FILL_W'(1);

    qpsk_slicer u_slicer (
        .clk      (clk),
        .rst      (rst),
        .in_valid (strobe_c),
        .in_i     (in_i),
        .in_q     (in_q),
        .dibit    (dibit),
        .dvalid   (dvalid)
    );

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            phase_q    <= '0;
            len_q      <= '0;
            sr         <= '0;
            fill       <= '0;
            pk         <= '0;
            dcnt       <= '0;
            bcnt       <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            sync_found <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            phase_q    <= phase_d;
            len_q      <= len_d;
            sr         <= sr_d;
            fill       <= fill_d;
            pk         <= pk_d;
            dcnt       <= dcnt_d;
            bcnt       <= bcnt_d;
            byte_data  <= byte_data_d;
            byte_valid <= byte_valid_d;
            sync_found <= sync_found_d;
            frame_done <= frame_done_d;
            overflow   <= overflow_d;
            busy       <= busy_d;
        end
    end

    // Next-state, packer and output-register logic
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        phase_d      = phase_q;
        len_d        = len_q;
        sr_d         = sr;
        fill_d       = fill;
        pk_d         = pk;
        dcnt_d       = dcnt;
        bcnt_d       = bcnt;
        byte_data_d  = byte_data;
        byte_valid_d = byte_valid;
        overflow_d   = overflow;
        sync_found_d = 1'b0;
        frame_done_d = 1'b0;
        complete     = 1'b0;

        if (in_valid) begin
            cnt_d = (cnt == PH_W'(SPS - 1)) ? '0 : cnt + PH_W'(1);
        end
        if (byte_valid && byte_ready) begin
            byte_valid_d = 1'b0;
        end

        case (state)
            IDLE: begin
                sr_d   = '0;
                fill_d = '0;
                if (en) begin
                    state_d    = HUNT;
                    cnt_d      = '0;
                    phase_d    = phase;
                    len_d      = (payload_len == '0) ? LEN_W'(1) : payload_len;
                    overflow_d = 1'b0;
                end
            end
            HUNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (dvalid) begin
                    sr_d   = sr_upd_c;
                    fill_d = fill_upd_c;
                    // Overlapping search; a match needs a full word received since clear
                    if (fill_upd_c == FILL_W'(SYNC_DIBITS) &&
                        sr_upd_c == SYNC_WORD[SR_W-1:0]) begin
                        sync_found_d = 1'b1;
                        state_d      = PAYLOAD;
                        pk_d         = '0;
                        dcnt_d       = '0;
                        bcnt_d       = '0;
                    end
                end
            end
            PAYLOAD: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (dvalid) begin
                    pk_d   = {pk[3:0], dibit};
                    dcnt_d = dcnt + 2'd1;
                    if (dcnt == 2'd3) begin
                        complete = 1'b1;
                        if (bcnt == len_q - LEN_W'(1)) begin
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            bcnt_d = bcnt + LEN_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                sr_d   = '0;
                fill_d = '0;
                if (en) begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completed byte only lands if the single entry is free or draining this cycle
        if (complete) begin
            if (!byte_valid || byte_ready) begin
                byte_data_d  = {pk, dibit};
                byte_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_qpsk_rx_frame_ctrl.sv
// Directed self-checking bench for qpsk_rx_frame_ctrl (SPS=4, sync D391).
module tb_qpsk_rx_frame_ctrl;

    logic               clk;
    logic               rst;
    logic               en;
    logic [1:0]         phase;
    logic [7:0]         payload_len;
    logic               in_valid;
    logic signed [15:0] in_i;
    logic signed [15:0] in_q;
    logic [7:0]         byte_data;
    logic               byte_valid;
    logic               byte_ready;
    logic               sync_found;
    logic               frame_done;
    logic               overflow;
    logic               busy;

    int errors = 0;
    int checks = 0;

    // Event log filled by the monitor below
    int         cyc      = 0;
    int         n_dv     = 0;
    int         n_sync   = 0;
    int         n_done   = 0;
    int         sync_at  = 0;
    int         done_cyc = -1;
    int         acc_cyc  = -2;
    logic [1:0] dq[$];
    logic [7:0] bq[$];

    qpsk_rx_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .phase       (phase),
        .payload_len (payload_len),
        .in_valid    (in_valid),
        .in_i        (in_i),
        .in_q        (in_q),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .sync_found  (sync_found),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dut.u_slicer.dvalid) begin
            n_dv = n_dv + 1;
            dq.push_back(dut.u_slicer.dibit);
        end
        if (sync_found) begin
            n_sync  = n_sync + 1;
            sync_at = n_dv;
        end
        if (frame_done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (byte_valid && byte_ready) begin
            bq.push_back(byte_data);
            acc_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One symbol period; the sample on the strobe phase carries (i,q), others a filler
    task automatic send_raw(input logic signed [15:0] i, input logic signed [15:0] q);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            if (k == int'(phase)) begin
                in_i = i;
                in_q = q;
            end else begin
                in_i = 16'sd50;
                in_q = 16'sd50;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_sym(input logic [1:0] d);
        logic signed [15:0] i;
        logic signed [15:0] q;
        i = d[0] ? -16'sd100 : 16'sd100;
        q = d[1] ? -16'sd100 : 16'sd100;
        send_raw(i, q);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int j = 7; j >= 0; j--) send_sym(w[2*j+1 -: 2]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int j = 3; j >= 0; j--) send_sym(b[2*j+1 -: 2]);
    endtask

    // Return to IDLE, flush any held byte, then enter HUNT with phase 2
    task automatic start(input logic [7:0] len);
        en         = 1'b0;
        in_valid   = 1'b0;
        byte_ready = 1'b1;
        tick();
        tick();
        en          = 1'b1;
        phase       = 2'd2;
        payload_len = len;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; phase = 2'd0; payload_len = 8'd0;
        in_valid = 1'b0; in_i = 16'sd0; in_q = 16'sd0; byte_ready = 1'b0;
        tick();
        tick();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
        checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %h want 00", byte_data); end
        checks++; if (sync_found !== 1'b0) begin errors++; $display("FAIL reset_sync_found: got %b want 0", sync_found); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_strobe();
        int b;
        start(8'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hunt_busy: got %b want 1", busy); end
        b = n_dv;
        for (int k = 0; k < 12; k++) begin
            if (k == 6) begin
                // strobe-like values with in_valid low must be ignored
                in_valid = 1'b0; in_i = 16'sd128; in_q = -16'sd5;
                tick();
            end
            in_valid = 1'b1;
            if (k % 4 == 2) begin
                in_i = 16'sd128; in_q = -16'sd5;
            end else begin
                in_i = -16'sd7; in_q = 16'sd9;
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (n_dv - b !== 3) begin errors++; $display("FAIL strobe_count: got %0d want 3", n_dv - b); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (dq[b+j] !== 2'b10) begin errors++; $display("FAIL strobe_dibit%0d: got %b want 10", j, dq[b+j]); end
        end
    endtask

    task automatic test_sign_edge();
        logic signed [15:0] vi[4];
        logic signed [15:0] vq[4];
        logic [1:0]         ex[4];
        int b;
        vi[0] = 16'sd0;     vq[0] = 16'sd0;     ex[0] = 2'b11;
        vi[1] = 16'sd1;     vq[1] = 16'sd0;     ex[1] = 2'b10;
        vi[2] = 16'sd0;     vq[2] = 16'sd1;     ex[2] = 2'b01;
        vi[3] = 16'sh8000;  vq[3] = 16'sh7FFF;  ex[3] = 2'b01;
        start(8'd2);
        b = n_dv;
        for (int j = 0; j < 4; j++) send_raw(vi[j], vq[j]);
        tick();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (dq[b+j] !== ex[j]) begin errors++; $display("FAIL sign_edge%0d: got %b want %b", j, dq[b+j], ex[j]); end
        end
    endtask

    task automatic test_frame();
        int bs, ds, ss;
        start(8'd2);
        byte_ready = 1'b1;
        bs = bq.size(); ds = n_done; ss = n_sync;
        send_word(16'hD391);
        send_byte(8'hA5);
        send_byte(8'h3C);
        repeat (4) tick();
        checks++; if (n_sync - ss !== 1) begin errors++; $display("FAIL frame_sync_count: got %0d want 1", n_sync - ss); end
        checks++; if (bq.size() - bs !== 2) begin errors++; $display("FAIL frame_byte_count: got %0d want 2", bq.size() - bs); end
        checks++; if (bq[bs] !== 8'hA5) begin errors++; $display("FAIL frame_byte0: got %h want a5", bq[bs]); end
        checks++; if (bq[bs+1] !== 8'h3C) begin errors++; $display("FAIL frame_byte1: got %h want 3c", bq[bs+1]); end
        checks++; if (n_done - ds !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", n_done - ds); end
        checks++; if (done_cyc !== acc_cyc) begin errors++; $display("FAIL frame_done_timing: done cycle %0d, last byte cycle %0d, want equal", done_cyc, acc_cyc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_back_to_hunt: busy %b want 1", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frame_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_backpressure();
        int bs, ds;
        start(8'd2);
        byte_ready = 1'b0;
        bs = bq.size(); ds = n_done;
        send_word(16'hD391);
        send_byte(8'hA5);
        send_byte(8'h3C);
        repeat (4) tick();
        checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", byte_valid); end
        checks++; if (byte_data !== 8'hA5) begin errors++; $display("FAIL bp_data_held: got %h want a5", byte_data); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        checks++; if (n_done - ds !== 1) begin errors++; $display("FAIL bp_frame_done: got %0d want 1", n_done - ds); end
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        tick();
        checks++; if (bq.size() - bs !== 1) begin errors++; $display("FAIL bp_accepted: got %0d want 1", bq.size() - bs); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", byte_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_false_sync();
        int b, ss, ds, bs;
        start(8'd0);
        byte_ready = 1'b1;
        b = n_dv; ss = n_sync; ds = n_done; bs = bq.size();
        send_word(16'hD390);
        send_sym(2'b11);
        send_sym(2'b01);
        send_sym(2'b00);
        send_word(16'hD391);
        tick();
        checks++; if (n_sync - ss !== 1) begin errors++; $display("FAIL false_sync_count: got %0d want 1", n_sync - ss); end
        checks++; if (sync_at - b !== 19) begin errors++; $display("FAIL false_sync_position: got dibit %0d want 19", sync_at - b); end
        send_byte(8'h81);
        repeat (3) tick();
        checks++; if (n_done - ds !== 1) begin errors++; $display("FAIL len0_frame_done: got %0d want 1", n_done - ds); end
        checks++; if (bq.size() - bs !== 1 || bq[bs] !== 8'h81) begin errors++; $display("FAIL len0_byte: count %0d want 1", bq.size() - bs); end
    endtask

    task automatic test_abort();
        int bs, ds, ss;
        start(8'd1);
        byte_ready = 1'b1;
        bs = bq.size(); ds = n_done;
        send_word(16'hD391);
        send_sym(2'b10);
        send_sym(2'b01);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b want 0", busy); end
        repeat (6) tick();
        checks++; if (n_done - ds !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", n_done - ds); end
        checks++; if (bq.size() - bs !== 0 || byte_valid !== 1'b0) begin errors++; $display("FAIL abort_no_byte: count %0d valid %b want 0", bq.size() - bs, byte_valid); end

        // Async reset with a held byte and overflow pending mid-PAYLOAD
        start(8'd2);
        byte_ready = 1'b0;
        send_word(16'hD391);
        send_byte(8'hA5);
        send_sym(2'b11);
        checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", byte_valid); end
        ss = n_sync; ds = n_done;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", byte_valid); end
        checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %h want 00", byte_data); end
        en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (n_sync - ss !== 0 || n_done - ds !== 0) begin errors++; $display("FAIL rst_no_pulse: sync %0d done %0d want 0", n_sync - ss, n_done - ds); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_idle: busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_sign_edge();
        test_frame();
        test_backpressure();
        test_false_sync();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
